// File: rtl/seq_counter_ctrl_pkg.sv
// Shared types and reset defaults for the programmable sequence counter controller.
package seq_ctrl_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam int unsigned DEFAULT_LEN   = 5;
  localparam int unsigned DEFAULT_SEQ_N = 5;
  localparam int unsigned DEFAULT_SEQ [DEFAULT_SEQ_N] = '{0, 3, 5, 6, 2};

  // Entries past the fixed sequence default to zero.
  function automatic int unsigned default_entry(input int unsigned i);
    int unsigned v;
    v = 0;
    for (int unsigned k = 0; k < DEFAULT_SEQ_N; k++) begin
      if (k == i) v = DEFAULT_SEQ[k];
    end
    return v;
  endfunction

endpackage

// File: rtl/seq_counter_ctrl_if.sv
// Control/config/status bundle between the sequencer controller and its user.
interface seq_counter_ctrl_if #(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [W-1:0]     cfg_data;
  logic             cfg_len_we;
  logic [IDX_W:0]   cfg_len;
  logic             mode;
  logic             start;
  logic             stop;
  logic             step_en;
  logic [W-1:0]     count;
  logic             valid;
  logic             busy;
  logic             done;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_addr, cfg_data, cfg_len_we, cfg_len,
    output mode, start, stop, step_en,
    input  count, valid, busy, done, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, cfg_len_we, cfg_len,
    input  mode, start, stop, step_en,
    output count, valid, busy, done, cfg_err
  );

endinterface

// File: rtl/seq_counter_ctrl_table.sv
// DEPTH x W sequence table: one synchronous write port, one combinational read port.
module seq_table
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [W-1:0]               wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [W-1:0]               rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= W'(default_entry(i));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/seq_counter_ctrl.sv
// Steps a writable count table under step_en, one-shot or continuous; resets to 0,3,5,6,2.
module seq_counter_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 8
) (
  input logic              CLK,
  input logic              RESET,
  seq_counter_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic [IDX_W:0]   len;
  logic [W-1:0]     count;
  logic             valid, valid_n;
  logic             busy, busy_n;
  logic             done, done_n;
  logic             cfg_err, cfg_err_n;
  logic             mode_q, mode_n;
  logic             load;
  logic             cfg_window, len_ok, tbl_we, len_we;
  logic [W-1:0]     tbl_rdata;

  // The table is read at the next index so count can be registered on the same edge.
  seq_table #(.W(W), .DEPTH(DEPTH)) u_table (
    .CLK   (CLK),
    .RESET (RESET),
    .we    (tbl_we),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_data),
    .raddr (idx_n),
    .rdata (tbl_rdata)
  );

  always_comb begin
    cfg_window = (state == IDLE) && !bus.start;
    len_ok     = (bus.cfg_len != '0) && (bus.cfg_len <= (IDX_W+1)'(DEPTH));
    tbl_we     = bus.cfg_we && cfg_window;
    len_we     = bus.cfg_len_we && cfg_window && len_ok;
    cfg_err_n  = (bus.cfg_we && !cfg_window) ||
                 (bus.cfg_len_we && !(cfg_window && len_ok));
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    load    = 1'b0;
    valid_n = valid;
    busy_n  = busy;
    done_n  = 1'b0;
    mode_n  = mode_q;
    unique case (state)
      IDLE: begin
        valid_n = 1'b0;
        busy_n  = 1'b0;
        if (bus.start && !bus.stop) begin
          state_n = RUN;
          idx_n   = '0;
          load    = 1'b1;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          mode_n  = bus.mode;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_n = IDLE;
          valid_n = 1'b0;
          busy_n  = 1'b0;
        end else if (bus.step_en) begin
          if ({1'b0, idx} < (len - 1'b1)) begin
            idx_n = idx + 1'b1;
            load  = 1'b1;
          end else if (mode_q) begin
            idx_n = '0;
            load  = 1'b1;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
            valid_n = 1'b0;
            busy_n  = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      idx     <= '0;
      len     <= (IDX_W+1)'(DEFAULT_LEN);
      count   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      valid   <= valid_n;
      busy    <= busy_n;
      done    <= done_n;
      cfg_err <= cfg_err_n;
      mode_q  <= mode_n;
      if (load) count <= tbl_rdata;
      if (len_we) len <= bus.cfg_len;
    end
  end

  assign bus.count   = count;
  assign bus.valid   = valid;
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.cfg_err = cfg_err;

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Directed self-checking bench for seq_counter_ctrl; status packed as {count,valid,busy,done,cfg_err}.
module tb_seq_counter_ctrl;

  logic CLK;
  logic RESET;
  int   tests;
  int   fails;

  seq_counter_ctrl_if #(.W(3), .DEPTH(8)) bus ();

  seq_counter_ctrl #(.W(3), .DEPTH(8)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  logic [6:0] st;
  assign st = {bus.count, bus.valid, bus.busy, bus.done, bus.cfg_err};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;
    bus.cfg_len_we = 1'b0;
    bus.cfg_len    = '0;
    bus.mode       = 1'b0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.step_en    = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [2:0] d);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic len_write(input logic [3:0] l);
    bus.cfg_len_we = 1'b1; bus.cfg_len = l;
    tick();
    bus.cfg_len_we = 1'b0;
  endtask

  task automatic start_run(input logic m);
    bus.mode = m; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RESET = 1'b1;
    tick(); tick();
    RESET = 1'b0;
    tests++;
    if (st !== 7'b000_0000) begin
      fails++; $display("FAIL reset_state got %b exp %b", st, 7'b000_0000);
    end
  endtask

  task automatic test_oneshot();
    logic [2:0] seq [5] = '{3'd0, 3'd3, 3'd5, 3'd6, 3'd2};
    start_run(1'b0);
    tests++;
    if (st !== {3'd0, 4'b1100}) begin
      fails++; $display("FAIL oneshot_start got %b exp %b", st, {3'd0, 4'b1100});
    end
    bus.step_en = 1'b1;
    for (int i = 1; i < 5; i++) begin
      tick();
      tests++;
      if (st !== {seq[i], 4'b1100}) begin
        fails++; $display("FAIL oneshot_step%0d got %b exp %b", i, st, {seq[i], 4'b1100});
      end
    end
    tick();
    tests++;
    if (st !== {3'd2, 4'b0010}) begin
      fails++; $display("FAIL oneshot_done got %b exp %b", st, {3'd2, 4'b0010});
    end
    bus.step_en = 1'b0;
    tick();
    tests++;
    if (st !== {3'd2, 4'b0000}) begin
      fails++; $display("FAIL oneshot_after got %b exp %b", st, {3'd2, 4'b0000});
    end
  endtask

  task automatic test_continuous();
    logic [2:0] seq [5] = '{3'd0, 3'd3, 3'd5, 3'd6, 3'd2};
    start_run(1'b1);
    bus.mode = 1'b0;
    tests++;
    if (st !== {3'd0, 4'b1100}) begin
      fails++; $display("FAIL cont_start got %b exp %b", st, {3'd0, 4'b1100});
    end
    for (int k = 1; k <= 12; k++) begin
      bus.step_en = 1'b1;
      tick();
      bus.step_en = 1'b0;
      tests++;
      if (st !== {seq[k % 5], 4'b1100}) begin
        fails++; $display("FAIL cont_step%0d got %b exp %b", k, st, {seq[k % 5], 4'b1100});
      end
      tick();
      tests++;
      if (st !== {seq[k % 5], 4'b1100}) begin
        fails++; $display("FAIL cont_hold%0d got %b exp %b", k, st, {seq[k % 5], 4'b1100});
      end
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tests++;
    if (st !== {3'd5, 4'b0000}) begin
      fails++; $display("FAIL cont_stop got %b exp %b", st, {3'd5, 4'b0000});
    end
  endtask

  task automatic test_cfg_write();
    logic [2:0] seq [3] = '{3'd7, 3'd1, 3'd4};
    cfg_write(3'd0, 3'd7);
    cfg_write(3'd1, 3'd1);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd2; bus.cfg_data = 3'd4;
    bus.cfg_len_we = 1'b1; bus.cfg_len = 4'd3;
    tick();
    bus.cfg_we = 1'b0; bus.cfg_len_we = 1'b0;
    tests++;
    if (st !== {3'd5, 4'b0000}) begin
      fails++; $display("FAIL cfg_accept got %b exp %b", st, {3'd5, 4'b0000});
    end
    for (int pass = 0; pass < 2; pass++) begin
      start_run(1'b0);
      bus.step_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (st !== {seq[i], 4'b1100}) begin
          fails++; $display("FAIL cfg_run%0d_%0d got %b exp %b", pass, i, st, {seq[i], 4'b1100});
        end
        tick();
      end
      bus.step_en = 1'b0;
      tests++;
      if (st !== {3'd4, 4'b0010}) begin
        fails++; $display("FAIL cfg_done%0d got %b exp %b", pass, st, {3'd4, 4'b0010});
      end
      tick();
      if (pass == 0) begin
        len_write(4'd0);
        tests++;
        if (st !== {3'd4, 4'b0001}) begin
          fails++; $display("FAIL cfg_len0_err got %b exp %b", st, {3'd4, 4'b0001});
        end
        len_write(4'd9);
        tests++;
        if (st !== {3'd4, 4'b0001}) begin
          fails++; $display("FAIL cfg_len9_err got %b exp %b", st, {3'd4, 4'b0001});
        end
        tick();
        tests++;
        if (st !== {3'd4, 4'b0000}) begin
          fails++; $display("FAIL cfg_err_clear got %b exp %b", st, {3'd4, 4'b0000});
        end
      end
    end
  endtask

  task automatic test_run_reject();
    cfg_write(3'd0, 3'd0);
    cfg_write(3'd1, 3'd3);
    cfg_write(3'd2, 3'd5);
    len_write(4'd5);
    start_run(1'b0);
    bus.cfg_we = 1'b1; bus.cfg_addr = 3'd1; bus.cfg_data = 3'd7;
    tick();
    bus.cfg_we = 1'b0;
    tests++;
    if (st !== {3'd0, 4'b1101}) begin
      fails++; $display("FAIL run_wr_err got %b exp %b", st, {3'd0, 4'b1101});
    end
    bus.step_en = 1'b1;
    tick();
    tests++;
    if (st !== {3'd3, 4'b1100}) begin
      fails++; $display("FAIL run_tbl_kept got %b exp %b", st, {3'd3, 4'b1100});
    end
    tick();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0; bus.step_en = 1'b0;
    tests++;
    if (st !== {3'd5, 4'b0000}) begin
      fails++; $display("FAIL run_stop got %b exp %b", st, {3'd5, 4'b0000});
    end
    tick();
    tests++;
    if (st !== {3'd5, 4'b0000}) begin
      fails++; $display("FAIL run_stop_hold got %b exp %b", st, {3'd5, 4'b0000});
    end
  endtask

  task automatic test_start_stop_reset();
    logic [2:0] seq [5] = '{3'd0, 3'd3, 3'd5, 3'd6, 3'd2};
    bus.start = 1'b1; bus.stop = 1'b1;
    tick();
    bus.start = 1'b0; bus.stop = 1'b0;
    tests++;
    if (st !== {3'd5, 4'b0000}) begin
      fails++; $display("FAIL start_stop_idle got %b exp %b", st, {3'd5, 4'b0000});
    end
    cfg_write(3'd4, 3'd7);
    len_write(4'd4);
    start_run(1'b0);
    bus.step_en = 1'b1;
    tick(); tick(); tick();
    bus.step_en = 1'b0;
    tests++;
    if (st !== {3'd6, 4'b1100}) begin
      fails++; $display("FAIL pre_reset got %b exp %b", st, {3'd6, 4'b1100});
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tests++;
    if (st !== {3'd0, 4'b0000}) begin
      fails++; $display("FAIL mid_reset got %b exp %b", st, {3'd0, 4'b0000});
    end
    start_run(1'b0);
    bus.step_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (st !== {seq[i], 4'b1100}) begin
        fails++; $display("FAIL reset_defaults%0d got %b exp %b", i, st, {seq[i], 4'b1100});
      end
      tick();
    end
    bus.step_en = 1'b0;
    tests++;
    if (st !== {3'd2, 4'b0010}) begin
      fails++; $display("FAIL reset_len_done got %b exp %b", st, {3'd2, 4'b0010});
    end
    tick();
  endtask

  task automatic test_len_one();
    cfg_write(3'd0, 3'd6);
    len_write(4'd1);
    start_run(1'b1);
    bus.mode = 1'b0;
    tests++;
    if (st !== {3'd6, 4'b1100}) begin
      fails++; $display("FAIL len1_start got %b exp %b", st, {3'd6, 4'b1100});
    end
    bus.step_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (st !== {3'd6, 4'b1100}) begin
        fails++; $display("FAIL len1_step%0d got %b exp %b", i, st, {3'd6, 4'b1100});
      end
    end
    bus.step_en = 1'b0;
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tests++;
    if (st !== {3'd6, 4'b0000}) begin
      fails++; $display("FAIL len1_stop got %b exp %b", st, {3'd6, 4'b0000});
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    RESET = 1'b1;
    idle_inputs();
    test_reset();
    test_oneshot();
    test_continuous();
    test_cfg_write();
    test_run_reject();
    test_start_stop_reset();
    test_len_one();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_counter_ctrl.md
Name: seq_counter_ctrl

Overview:
Controller that sequences a programmable-sequence counter. It holds a small writable table of W-bit count values and a sequence length. On start, it steps through the table, gated by a step-enable tick, in one-shot or continuous mode. Reset defaults reproduce the team's fixed 0,3,5,6,2 counter sequence, so the block drops in as a configurable replacement in the counter datapath.

Parameters:
W, 3, width of each count value
DEPTH, 8, number of table entries; power of two, >= 2
IDX_W, $clog2(DEPTH), table index width (derived)

Ports:
CLK  in  1  single clock; all logic on its rising edge
RESET  in  1  synchronous, active-high reset
cfg_we  in  1  table write strobe
cfg_addr  in  IDX_W  table write address
cfg_data  in  W  table write data
cfg_len_we  in  1  length register write strobe
cfg_len  in  IDX_W+1  sequence length, legal range 1..DEPTH
mode  in  1  0 = one-shot, 1 = continuous; sampled when start is accepted
start  in  1  level-sampled run request
stop  in  1  abort request
step_en  in  1  advance tick
count  out  W  current sequence value (registered)
valid  out  1  count is a live sequence value
busy  out  1  high while in RUN
done  out  1  one-cycle pulse at end of a one-shot run
cfg_err  out  1  one-cycle pulse when a config write is rejected

Behaviour:
- Reset: all state is synchronous with CLK; there is no async path.
  - Reset values: state=IDLE, idx=0, count=0, valid=0, busy=0, done=0, cfg_err=0, len=5, mode_q=0.
  - Table reset contents: {0,3,5,6,2,0,0,0}; entries 5..DEPTH-1 = 0.
- RESET asserted mid-run: the next edge restores every reset value, including table and len. done is not pulsed.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 and stop=0 -> RUN on the next edge. Same edge: idx=0, count=table[0], valid=1, busy=1, mode_q=mode. Latency is 1 cycle.
  - start=1 and stop=1 together -> stop wins; remain IDLE.
  - count holds its last value; valid=0.
- RUN, priority order stop > step_en:
  - stop=1 -> IDLE on the next edge. valid=0, busy=0, no done pulse, count holds.
  - step_en=1 and idx < len-1 -> idx+1, count=table[idx+1].
  - step_en=1, idx == len-1, mode_q=1 -> idx=0, count=table[0] (wrap-around).
  - step_en=1, idx == len-1, mode_q=0 -> IDLE. done=1 for exactly one cycle, valid=0, busy=0, count holds the last value.
  - step_en=0 -> hold.
  - start is ignored in RUN.
- len=1: each step reloads table[0]. In one-shot, the first step_en ends the run.
- Config writes:
  - Accepted only in IDLE, and only with no start in the same cycle.
  - Otherwise the write is dropped and cfg_err pulses one cycle later.
  - A cfg_len outside 1..DEPTH is dropped with cfg_err.
  - cfg_we and cfg_len_we in the same cycle are both applied.
  - Writes take effect on the next edge.
- All outputs are registered; no combinational input-to-output paths.

Decomposition:
- Package seq_ctrl_pkg holds:
  - state enum {IDLE, RUN}
  - DEFAULT_LEN = 5
  - DEFAULT_SEQ constant array {0,3,5,6,2}
- Sub-module seq_table:
  - DEPTH x W register file
  - one synchronous write port, one combinational read port
  - reset loads DEFAULT_SEQ
- seq_counter_ctrl holds the FSM, idx, len, and the count/flag registers.

Test Plan:
1. Reset, then start=1 for one cycle with mode=0, then step_en held high -> count 0,3,5,6,2 on consecutive cycles with valid=1. done pulses on the cycle after the step from 2; busy and valid drop; count stays 2.
2. mode=1, start, step_en every other cycle for 12 steps -> 0,3,5,6,2,0,3,... Each value holds 2 cycles. done never asserts.
3. In IDLE write table[0..2]={7,1,4}, cfg_len=3, then one-shot run -> 7,1,4, then done. Then a cfg_len=0 write -> cfg_err pulse, len stays 3.
4. During RUN, cfg_we to addr 1 -> cfg_err pulse, table unchanged. Then stop together with step_en at count=5 -> IDLE next cycle, count holds 5, no done.
5. start and stop asserted together in IDLE -> stays IDLE, busy=0. RESET asserted at count=6 mid-run -> next cycle count=0, valid=0, len=5, table back to defaults.
6. cfg_len=1 with table[0]=6, continuous run, step_en high for 4 cycles -> count constant 6, valid=1, busy=1.
